// File: rtl/k_lpf_tdm_scheduler.sv
// Time-shared single-pole low-pass filter for N_CH channels: one sample strobe
// starts a frame that updates one channel per clock, then pulses out_valid.
module k_lpf_tdm_scheduler #(
  parameter int N_CH = 4,
  parameter int K    = 26
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 sample_strobe_i,
  input  logic [16*N_CH-1:0]   x_bus_i,
  input  logic [N_CH-1:0]      ch_clear_i,
  output logic [16*N_CH-1:0]   y_bus_o,
  output logic                 out_valid_o,
  output logic                 busy_o,
  output logic                 overrun_o
);

  localparam int IDXW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic signed [47:0] INIT48 = 48'sh2000_0000_0000;
  localparam logic [15:0] INIT16 = 16'h2000;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_CH-1);

  logic [0:0]          state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic                overrun_q, overrun_d;
  logic [16*N_CH-1:0]  xbuf_q, xbuf_d;
  logic [N_CH-1:0]     pend_q, pend_d;

  logic signed [47:0]  xp_q [N_CH];
  logic signed [47:0]  yf_q [N_CH];
  logic [15:0]         yout_q [N_CH];

  logic [N_CH-1:0]     slot_s;
  logic                clr_s;
  logic signed [15:0]  xc_s;
  logic signed [47:0]  xp_sel_s, yf_sel_s, w1_s, s_s, yn_s;

  // Select the channel being processed this cycle and compute its update.
  always_comb begin
    xc_s     = 16'sh0000;
    xp_sel_s = 48'sh0;
    yf_sel_s = 48'sh0;
    slot_s   = {N_CH{1'b0}};
    for (int c = 0; c < N_CH; c++) begin
      slot_s[c] = (state_q == S_RUN) && (idx_q == IDXW'(c));
      xc_s      = slot_s[c] ? xbuf_q[16*c +: 16] : xc_s;
      xp_sel_s  = slot_s[c] ? xp_q[c] : xp_sel_s;
      yf_sel_s  = slot_s[c] ? yf_q[c] : yf_sel_s;
    end
    clr_s = |(slot_s & (pend_q | ch_clear_i));
    w1_s  = {xc_s, 32'h0000_0000};
    s_s   = (w1_s + xp_sel_s) >>> K;
    yn_s  = yf_sel_s + s_s - (yf_sel_s >>> (K-1));
  end

  // Frame sequencing, clear bookkeeping and status flags.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    xbuf_d      = xbuf_q;
    pend_d      = (pend_q | ch_clear_i) & ~slot_s;
    case (state_q)
      S_IDLE: begin
        if (sample_strobe_i && enable_i) begin
          xbuf_d  = x_bus_i;
          idx_d   = {IDXW{1'b0}};
          state_d = S_RUN;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (sample_strobe_i && enable_i) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d     = S_IDLE;
          idx_d       = {IDXW{1'b0}};
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          idx_d       = idx_q + IDXW'(1'b1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = {IDXW{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      idx_q       <= {IDXW{1'b0}};
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      xbuf_q      <= {16*N_CH{1'b0}};
      pend_q      <= {N_CH{1'b0}};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      xbuf_q      <= xbuf_d;
      pend_q      <= pend_d;
    end
  end

  // Per-channel filter state; only the channel in its slot is written.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < N_CH; c++) begin
      if (reset_i || (slot_s[c] && clr_s)) begin
        xp_q[c]   <= INIT48;
        yf_q[c]   <= INIT48;
        yout_q[c] <= INIT16;
      end else if (slot_s[c]) begin
        xp_q[c]   <= w1_s;
        yf_q[c]   <= yn_s;
        yout_q[c] <= yn_s[47:32];
      end
    end
  end

  // Pack the held outputs onto the bus.
  always_comb begin
    y_bus_o = {16*N_CH{1'b0}};
    for (int c = 0; c < N_CH; c++) begin
      y_bus_o[16*c +: 16] = yout_q[c];
    end
  end

  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_k_lpf_tdm_scheduler.sv
// Bench for k_lpf_tdm_scheduler: two instances (K=26 default and K=6 for fast
// visible dynamics) share stimulus and are scored against a frame-level model.
module tb_k_lpf_tdm_scheduler;
  localparam int N  = 4;
  localparam int KA = 26;
  localparam int KB = 6;
  localparam logic [16*N-1:0] ALL2000 = {N{16'h2000}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst  = 1'b1;
  logic            en   = 1'b0;
  logic            strb = 1'b0;
  logic [16*N-1:0] xb   = '0;
  logic [N-1:0]    clr  = '0;
  logic [16*N-1:0] y_a, y_b;
  logic vo_a, vo_b, bz_a, bz_b, ov_a, ov_b;

  k_lpf_tdm_scheduler #(.N_CH(N), .K(KA)) dut_a (
    .clk_i(clk), .reset_i(rst), .enable_i(en), .sample_strobe_i(strb),
    .x_bus_i(xb), .ch_clear_i(clr), .y_bus_o(y_a), .out_valid_o(vo_a),
    .busy_o(bz_a), .overrun_o(ov_a));

  k_lpf_tdm_scheduler #(.N_CH(N), .K(KB)) dut_b (
    .clk_i(clk), .reset_i(rst), .enable_i(en), .sample_strobe_i(strb),
    .x_bus_i(xb), .ch_clear_i(clr), .y_bus_o(y_b), .out_valid_o(vo_b),
    .busy_o(bz_b), .overrun_o(ov_b));

  int checks   = 0;
  int failures = 0;

  // Reference model: filter state per instance, plus shared frame bookkeeping.
  logic signed [47:0] m_xp [2][N];
  logic signed [47:0] m_yf [2][N];
  logic [15:0]        m_y  [2][N];
  logic [N-1:0]       m_pend;
  logic [16*N-1:0]    m_frame;
  int                 m_age;   // channel due next in the running frame, -1 when idle
  logic               m_ov, m_vld;

  function automatic logic signed [47:0] lpf_next(input logic signed [15:0] x,
      input logic signed [47:0] xp, input logic signed [47:0] yf, input int k);
    logic signed [47:0] w1;
    w1 = {x, 32'h0};
    return yf + ((w1 + xp) >>> k) - (yf >>> (k-1));
  endfunction

  task automatic model_init();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < N; c++) begin
        m_xp[i][c] = 48'sh2000_0000_0000;
        m_yf[i][c] = 48'sh2000_0000_0000;
        m_y[i][c]  = 16'h2000;
      end
    m_pend = '0; m_frame = '0; m_age = -1; m_ov = 1'b0; m_vld = 1'b0;
  endtask

  task automatic model_edge(input logic r, input logic e, input logic s,
                            input logic [16*N-1:0] x, input logic [N-1:0] c);
    int   ch;
    logic wipe;
    logic signed [15:0] xs;
    if (r) begin
      model_init();
      return;
    end
    m_vld = 1'b0;
    if (m_age >= 0) begin
      ch   = m_age;
      wipe = m_pend[ch] | c[ch];
      m_pend = m_pend | c;
      m_pend[ch] = 1'b0;
      xs = m_frame[16*ch +: 16];
      for (int i = 0; i < 2; i++) begin
        if (wipe) begin
          m_xp[i][ch] = 48'sh2000_0000_0000;
          m_yf[i][ch] = 48'sh2000_0000_0000;
          m_y[i][ch]  = 16'h2000;
        end else begin
          m_yf[i][ch] = lpf_next(xs, m_xp[i][ch], m_yf[i][ch], (i == 0) ? KA : KB);
          m_xp[i][ch] = {xs, 32'h0};
          m_y[i][ch]  = m_yf[i][ch][47:32];
        end
      end
      if (s && e) m_ov = 1'b1;
      m_age++;
      if (m_age == N) begin
        m_age = -1;
        m_vld = 1'b1;
      end
    end else begin
      m_pend = m_pend | c;
      if (s && e) begin
        m_frame = x;
        m_age   = 0;
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, score the outputs 1 ns later.
  task automatic tick(input logic r, input logic e, input logic s,
                      input logic [16*N-1:0] x, input logic [N-1:0] c);
    logic [16*N-1:0] ea, eb;
    rst = r; en = e; strb = s; xb = x; clr = c;
    @(posedge clk);
    model_edge(r, e, s, x, c);
    #1;
    for (int k = 0; k < N; k++) begin
      ea[16*k +: 16] = m_y[0][k];
      eb[16*k +: 16] = m_y[1][k];
    end
    checks++;
    if (y_a !== ea) begin failures++; $display("FAIL sb_y_k26 t=%0t got=%h exp=%h", $time, y_a, ea); end
    checks++;
    if (y_b !== eb) begin failures++; $display("FAIL sb_y_k6 t=%0t got=%h exp=%h", $time, y_b, eb); end
    checks++;
    if ({vo_a, vo_b} !== {2{m_vld}}) begin failures++; $display("FAIL sb_out_valid t=%0t got=%b%b exp=%b", $time, vo_a, vo_b, m_vld); end
    checks++;
    if ({bz_a, bz_b} !== {2{m_age >= 0}}) begin failures++; $display("FAIL sb_busy t=%0t got=%b%b exp=%b", $time, bz_a, bz_b, m_age >= 0); end
    checks++;
    if ({ov_a, ov_b} !== {2{m_ov}}) begin failures++; $display("FAIL sb_overrun t=%0t got=%b%b exp=%b", $time, ov_a, ov_b, m_ov); end
  endtask

  function automatic logic [16*N-1:0] rand_x();
    logic [16*N-1:0] v;
    for (int k = 0; k < N; k++) v[16*k +: 16] = 16'($urandom);
    return v;
  endfunction

  task automatic do_reset();
    tick(1'b1, 1'b1, 1'b0, xb, '0);
  endtask

  task automatic run_frame(input logic [16*N-1:0] x);
    tick(1'b0, 1'b1, 1'b1, x, '0);
    repeat (N) tick(1'b0, 1'b1, 1'b0, x, '0);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, rand_x(), '0);
    tick(1'b1, 1'b1, 1'b1, rand_x(), '0);
    checks++;
    if (y_a !== ALL2000 || y_b !== ALL2000) begin failures++; $display("FAIL reset_y got=%h/%h exp=%h", y_a, y_b, ALL2000); end
    checks++;
    if ({bz_a, vo_a, ov_a, bz_b, vo_b, ov_b} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {bz_a, vo_a, ov_a, bz_b, vo_b, ov_b}); end
  endtask

  task automatic test_reset_hold();
    int lat;
    do_reset();
    repeat (4) begin
      tick(1'b0, 1'b1, 1'b1, ALL2000, '0);
      lat = 1;
      while (!vo_a && lat < 20) begin
        tick(1'b0, 1'b1, 1'b0, ALL2000, '0);
        lat++;
      end
      checks++;
      if (lat != N + 1) begin failures++; $display("FAIL hold_latency got=%0d exp=%0d", lat, N + 1); end
      checks++;
      if (y_a !== ALL2000 || y_b !== ALL2000) begin failures++; $display("FAIL hold_y got=%h/%h exp=%h", y_a, y_b, ALL2000); end
      while (lat < 8) begin
        tick(1'b0, 1'b1, 1'b0, ALL2000, '0);
        lat++;
      end
    end
    checks++;
    if (ov_a !== 1'b0) begin failures++; $display("FAIL hold_overrun got=%b exp=0", ov_a); end
  endtask

  task automatic test_step();
    logic [16*N-1:0] x;
    int d;
    x = {{(N-1){16'h2000}}, 16'h3000};
    do_reset();
    run_frame(x);
    checks++;
    if (y_a[15:0] !== 16'h2000) begin failures++; $display("FAIL step_k26_ch0 got=%h exp=2000", y_a[15:0]); end
    checks++;
    if (y_b[15:0] !== 16'h2040) begin failures++; $display("FAIL step_k6_ch0 got=%h exp=2040", y_b[15:0]); end
    checks++;
    if (y_b[16*N-1:16] !== ALL2000[16*N-1:16]) begin failures++; $display("FAIL step_others got=%h exp=%h", y_b[16*N-1:16], ALL2000[16*N-1:16]); end
    repeat (400) run_frame(x);
    d = int'(y_b[15:0]) - 32'h3000;
    checks++;
    if (d > 1 || d < -1) begin failures++; $display("FAIL step_converge got=%h exp=3000+-1", y_b[15:0]); end
  endtask

  task automatic test_overrun();
    logic [16*N-1:0] x;
    x = rand_x();
    do_reset();
    tick(1'b0, 1'b1, 1'b1, x, '0);
    tick(1'b0, 1'b1, 1'b0, x, '0);
    tick(1'b0, 1'b1, 1'b1, rand_x(), '0);
    checks++;
    if (ov_a !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", ov_a); end
    repeat (N + 3) tick(1'b0, 1'b1, 1'b0, x, '0);
    checks++;
    if (ov_a !== 1'b1 || bz_a !== 1'b0) begin failures++; $display("FAIL overrun_sticky got=%b busy=%b exp=1/0", ov_a, bz_a); end
    do_reset();
    tick(1'b0, 1'b0, 1'b1, rand_x(), '0);
    checks++;
    if (bz_a !== 1'b0 || ov_a !== 1'b0) begin failures++; $display("FAIL enable_low got busy=%b ov=%b exp=0/0", bz_a, ov_a); end
    repeat (N + 1) tick(1'b0, 1'b0, 1'b0, x, '0);
    // strobe landing on the last slot edge is dropped
    tick(1'b0, 1'b1, 1'b1, x, '0);
    repeat (N - 1) tick(1'b0, 1'b1, 1'b0, x, '0);
    tick(1'b0, 1'b1, 1'b1, rand_x(), '0);
    checks++;
    if (ov_a !== 1'b1 || bz_a !== 1'b0 || vo_a !== 1'b1) begin failures++; $display("FAIL last_slot_strobe got ov=%b busy=%b vld=%b exp=1/0/1", ov_a, bz_a, vo_a); end
    repeat (2) tick(1'b0, 1'b1, 1'b0, x, '0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (6) run_frame(rand_x());
    tick(1'b0, 1'b1, 1'b1, rand_x(), '0);
    checks++;
    if (ov_a !== 1'b0 || bz_a !== 1'b1) begin failures++; $display("FAIL b2b got ov=%b busy=%b exp=0/1", ov_a, bz_a); end
    repeat (N + 2) tick(1'b0, 1'b1, 1'b0, xb, '0);
  endtask

  task automatic test_clear();
    logic [15:0] prev;
    logic [16*N-1:0] x;
    do_reset();
    repeat (5) run_frame(rand_x());
    prev = y_b[47:32];
    tick(1'b0, 1'b1, 1'b0, xb, 4'b0100);
    checks++;
    if (y_b[47:32] !== prev) begin failures++; $display("FAIL clear_idle_hold got=%h exp=%h", y_b[47:32], prev); end
    run_frame(rand_x());
    checks++;
    if (y_a[47:32] !== 16'h2000 || y_b[47:32] !== 16'h2000) begin failures++; $display("FAIL clear_idle got=%h/%h exp=2000", y_a[47:32], y_b[47:32]); end
    repeat (3) run_frame(rand_x());
    x = rand_x();
    tick(1'b0, 1'b1, 1'b1, x, '0);
    tick(1'b0, 1'b1, 1'b0, x, '0);
    tick(1'b0, 1'b1, 1'b0, x, '0);
    tick(1'b0, 1'b1, 1'b0, x, 4'b0100);
    tick(1'b0, 1'b1, 1'b0, x, '0);
    checks++;
    if (y_b[47:32] !== 16'h2000) begin failures++; $display("FAIL clear_slot got=%h exp=2000", y_b[47:32]); end
    repeat (2) run_frame(rand_x());
  endtask

  task automatic test_reset_midframe();
    do_reset();
    tick(1'b0, 1'b1, 1'b1, rand_x(), '0);
    tick(1'b0, 1'b1, 1'b1, rand_x(), '0);
    tick(1'b1, 1'b1, 1'b0, xb, '0);
    checks++;
    if ({bz_a, vo_a, ov_a} !== 3'b000 || y_a !== ALL2000 || y_b !== ALL2000) begin
      failures++;
      $display("FAIL reset_mid got flags=%b y=%h/%h exp=000/%h", {bz_a, vo_a, ov_a}, y_a, y_b, ALL2000);
    end
    run_frame(rand_x());
    tick(1'b0, 1'b1, 1'b0, xb, '0);
  endtask

  task automatic test_random();
    logic [16*N-1:0] x;
    int nvalid;
    nvalid = 0;
    do_reset();
    repeat (3000) begin
      x = rand_x();
      x[31:16] = 16'h8000;
      tick(1'b0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0), x,
           ($urandom_range(0, 15) == 0) ? N'($urandom) : '0);
      if (vo_a) nvalid++;
    end
    checks++;
    if (nvalid < 50) begin failures++; $display("FAIL random_frames got=%0d exp>=50", nvalid); end
  endtask

  initial begin
    model_init();
    test_reset();
    test_reset_hold();
    test_step();
    test_overrun();
    test_back_to_back();
    test_clear();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
